// File: rtl/fdiv_stream_ctrl.sv
// Valid/ready front-end and result buffer for a fixed-latency, non-stallable FP divider.
// Handles IEEE-754 special operands itself and credit-limits issue so the result FIFO never overflows.
module fdiv_stream_ctrl #(
  parameter int DIV_LATENCY = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Packed as {special, flags[2:0], value[31:0]}; denormals are treated as signed zero.
  function automatic logic [35:0] special_decode(input logic [31:0] a, input logic [31:0] b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s;
    logic [35:0] r;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    s      = a[31] ^ b[31];
    r      = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      r = {1'b1, 3'b101, QNAN};
    end else if (b_zero && !a_inf) begin
      r = {1'b1, 3'b011, s, 8'hFF, 23'h0};
    end else if (a_inf) begin
      r = {1'b1, 3'b001, s, 8'hFF, 23'h0};
    end else if (a_zero || b_inf) begin
      r = {1'b1, 3'b001, s, 31'h0};
    end
    return r;
  endfunction

  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          accept, pop, fifo_wr;
  logic [35:0]   dec;
  logic [34:0]   wr_entry;
  logic          dl_vld_q [DIV_LATENCY];
  logic [35:0]   dl_pay_q [DIV_LATENCY];
  logic [34:0]   mem_q    [FIFO_DEPTH];

  // in_ready is decoded from the credit register alone; reset_n only forces it low during reset.
  assign in_ready = reset_n && (outstanding_q < CW'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign busy     = (outstanding_q != '0);
  assign dec      = special_decode(in_a, in_b);

  always_comb begin
    outstanding_d = outstanding_q;
    count_d       = count_q;
    if (accept && !pop) outstanding_d = outstanding_q + CW'(1);
    if (!accept && pop) outstanding_d = outstanding_q - CW'(1);
    if (fifo_wr && !pop) count_d = count_q + CW'(1);
    if (!fifo_wr && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
      div_a         <= '0;
      div_b         <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (accept) begin
        div_a <= in_a;
        div_b <= in_b;
      end
    end
  end

  // Delay line: tracks each request alongside the divider, never stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DIV_LATENCY; i++) dl_vld_q[i] <= 1'b0;
    end else begin
      dl_vld_q[0] <= accept;
      for (int i = 1; i < DIV_LATENCY; i++) dl_vld_q[i] <= dl_vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dl_pay_q[0] <= dec;
    for (int i = 1; i < DIV_LATENCY; i++) dl_pay_q[i] <= dl_pay_q[i-1];
  end

  // Result FIFO: written as each request leaves the delay line.
  assign fifo_wr  = dl_vld_q[DIV_LATENCY-1];
  assign wr_entry = {dl_pay_q[DIV_LATENCY-1][34:32],
                     dl_pay_q[DIV_LATENCY-1][35] ? dl_pay_q[DIV_LATENCY-1][31:0] : div_result};

  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign out_valid              = (count_q != '0);
  assign {out_flags, out_data}  = out_valid ? mem_q[rd_ptr_q] : 35'h0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_wr && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: doc/fdiv_stream_ctrl.md
Name: fdiv_stream_ctrl

Overview:
- Streaming valid/ready front-end and result buffer for the fixed-latency, non-stallable pipelined floating point divider.
- Accepts IEEE-754 single-precision operand pairs (dividend A, divisor B) from the DNN datapath and drives them into the divider.
- Handles the special cases the divider does not cover: zero, infinity, NaN, denormal.
- Re-aligns each divider result with its request, buffers results in a small FIFO, and credit-limits issue so no result is ever dropped under downstream backpressure.

Parameters:
- DIV_LATENCY, 16: cycles from operands on div_a/div_b until the matching div_result is valid. Integer, 1 or more.
- FIFO_DEPTH, 4: result FIFO entries. Power of two, 2 or more.

Ports:
- clk  input  1  single clock, all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  32  dividend, IEEE-754 single.
- in_b  input  32  divisor, IEEE-754 single.
- div_a  output  32  registered dividend to the divider.
- div_b  output  32  registered divisor to the divider.
- div_result  input  32  divider quotient.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes the head.
- out_data  output  32  quotient.
- out_flags  output  3  [2] invalid, [1] divide-by-zero, [0] special-case result substituted.
- busy  output  1  at least one request in flight or buffered.

Behaviour:
- Reset: async clear of in_ready's counter, delay line, FIFO pointers and count. While reset_n low: in_ready=0, out_valid=0, out_data=0, out_flags=0, div_a=0, div_b=0, busy=0. After release, in_ready=1 on the first cycle. Reset mid-operation discards all in-flight and buffered results with no output.
- Accept: at any edge with in_valid & in_ready. div_a<=in_a and div_b<=in_b on that edge; otherwise they hold their values.
- Credit counter `outstanding` (0..FIFO_DEPTH): +1 on accept, -1 on pop (out_valid & out_ready), unchanged when both happen on the same edge. in_ready = (outstanding < FIFO_DEPTH), decoded from the register only. There is no combinational path from out_ready or in_valid to in_ready. busy = (outstanding != 0).
- Delay line: DIV_LATENCY stages carrying {valid, special, special_value[31:0], flags[2:0]}, advanced every cycle, never stalled.
- An accept at edge k reaches the end of the delay line at edge k+DIV_LATENCY. On that edge the FIFO is written with special_value if special=1, otherwise div_result. out_valid is high after that edge, so request-to-output latency is DIV_LATENCY cycles. Order is strictly preserved.
- FIFO: registered head (out_data, out_flags valid whenever out_valid=1). Pointers wrap modulo FIFO_DEPTH. A simultaneous write and pop is allowed, including when the FIFO is full or holds one entry. The credit rule guarantees a write never arrives while full; a violation is a design-assertion failure.
- Special-case decode (combinational on in_a/in_b at accept). Denormal inputs are treated as signed zero. s = in_a[31]^in_b[31].
  - Either operand NaN -> 0x7FC00000, flags 101.
  - 0/0 or inf/inf -> 0x7FC00000, flags 101.
  - finite nonzero / 0 -> {s, 0x7F800000[30:0]}, flags 011.
  - inf / finite -> s, inf; flags 001.
  - 0 / nonzero, or finite / inf -> s, zero; flags 001.
  - Otherwise special=0, flags 000.
- Special requests still drive div_a/div_b; the divider output for them is ignored.
- No rounding, overflow or underflow handling is done on div_result; it is forwarded unchanged.

Test Plan:
- Single request 6.0/2.0 (0x40C00000/0x40000000) with out_ready=1: out_valid rises exactly DIV_LATENCY cycles after accept; out_data equals the divider model (≈0x40400000); flags=000; busy drops the cycle after the pop.
- Back-to-back 8 requests with out_ready=0: exactly 4 accepted, then in_ready=0. Raise out_ready for one cycle: in_ready=1 the next cycle. All 8 results emerge in issue order.
- Specials: 1.0/0 -> 0x7F800000 flags 011; -1.0/0 -> 0xFF800000 flags 011; 0/0 -> 0x7FC00000 flags 101; inf/inf -> 0x7FC00000 flags 101; 3.0/inf -> 0x00000000 flags 001; denormal 0x00000001 / 2.0 -> 0x00000000 flags 001.
- Mixed stream of special and normal requests with random out_ready toggling: output order and values match the scoreboard; outstanding never exceeds 4.
- FIFO full with simultaneous pop and accept on the same edge: outstanding stays 4, no loss or duplication, pointer wrap exercised across more than 12 requests.
- Assert reset_n low asynchronously with 3 requests in flight and 2 buffered: outputs go to 0 immediately. After release, no stale result appears and in_ready=1.
